// File: rtl/cordic_iter_engine_if.sv
// ---------------------------------------------------------------------------
// cordic_iter_engine_if
//
// Purpose: bundles the angle-in and result-out handshakes of the iterative
// CORDIC engine into one port.
//
// Signals:
//   in_valid  - upstream presents an angle
//   in_ready  - engine can take an angle (IDLE only)
//   angle_in  - signed Q2.19 angle in radians
//   out_valid - result valid, held until out_ready
//   out_ready - downstream takes the result
//   cos_out   - signed Q2.19 cosine (final x)
//   sin_out   - signed Q2.19 sine (final y), only with CORDIC_SIN_OUT_EN
//   busy      - engine is iterating
//
// Modports: master = the surrounding pipeline (drives in_valid/angle_in and
// out_ready); slave = the engine itself.
// Build option: CORDIC_SIN_OUT_EN adds sin_out.
// ---------------------------------------------------------------------------
interface cordic_iter_engine_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [20:0] angle_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [20:0] cos_out;
`ifdef CORDIC_SIN_OUT_EN
  logic signed [20:0] sin_out;
`endif
  logic               busy;

  modport master (
    output in_valid,
    output angle_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  cos_out,
`ifdef CORDIC_SIN_OUT_EN
    input  sin_out,
`endif
    input  busy
  );

  modport slave (
    input  in_valid,
    input  angle_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output cos_out,
`ifdef CORDIC_SIN_OUT_EN
    output sin_out,
`endif
    output busy
  );
endinterface

// File: rtl/cordic_iter_engine.sv
// ---------------------------------------------------------------------------
// cordic_iter_engine
//
// Purpose: iterative rotation-mode CORDIC for the cosine accelerator. One
// angle is taken over a valid/ready handshake, seeded as x = K_INIT, y = 0,
// z = clamp(angle), then one micro-rotation is applied per clock for
// ITERATIONS clocks. The final x (and optionally y) is held on the output
// handshake until the downstream stage takes it.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high; clears all state
//   bus   - cordic_iter_engine_if.slave (angle in, result out, busy)
//
// Parameters:
//   ITERATIONS - micro-rotations per angle, legal 1..16 (4-bit index)
//   K_INIT     - gain compensation seed, 0.6072529 in Q2.19
//
// Build option: CORDIC_SIN_OUT_EN drives sin_out with the final y.
//
// Timing: out_valid rises on the same edge that applies the last rotation,
// i.e. on the (ITERATIONS+1)-th edge counting the accept edge as the first.
// With out_ready held high one angle is taken every ITERATIONS+2 cycles.
// ---------------------------------------------------------------------------
module cordic_iter_engine #(
  parameter int                 ITERATIONS = 16,
  parameter logic signed [20:0] K_INIT     = 21'sd318375
) (
  input  logic                clk,
  input  logic                reset,
  cordic_iter_engine_if.slave bus
);

  localparam logic signed [20:0] HALF_PI  = 21'sd823550;
  localparam logic [3:0]         LAST_IDX = 4'(ITERATIONS - 1);

  // atan(2^-i) in Q2.19, rounded to nearest
  localparam logic signed [20:0] ATAN [16] = '{
    21'sd411775, 21'sd243084, 21'sd128439, 21'sd65198,
    21'sd32725,  21'sd16379,  21'sd8191,   21'sd4096,
    21'sd2048,   21'sd1024,   21'sd512,    21'sd256,
    21'sd128,    21'sd64,     21'sd32,     21'sd16
  };

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  state_t             state_q, state_d;
  logic signed [20:0] x_q, x_d;
  logic signed [20:0] y_q, y_d;
  logic signed [20:0] z_q, z_d;
  logic [3:0]         idx_q, idx_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic signed [20:0] x_rot, y_rot, z_rot;
  logic signed [20:0] angle_clamped;

  // Angles beyond +/-pi/2 are pinned to the edge of CORDIC convergence.
  always_comb begin
    angle_clamped = bus.angle_in;
    if (bus.angle_in > HALF_PI) begin
      angle_clamped = HALF_PI;
    end else if (bus.angle_in < -HALF_PI) begin
      angle_clamped = -HALF_PI;
    end
  end

  // Single micro-rotation; z >= 0 rotates positive. Sums wrap at 21 bits.
  always_comb begin
    x_rot = x_q;
    y_rot = y_q;
    z_rot = z_q;
    if (z_q >= 0) begin
      x_rot = x_q - (y_q >>> idx_q);
      y_rot = y_q + (x_q >>> idx_q);
      z_rot = z_q - ATAN[idx_q];
    end else begin
      x_rot = x_q + (y_q >>> idx_q);
      y_rot = y_q - (x_q >>> idx_q);
      z_rot = z_q + ATAN[idx_q];
    end
  end

  // Next-state and registered-output logic. out_valid is raised together
  // with the final rotation so the result appears on the DONE entry edge.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d    = ROTATE;
          x_d        = K_INIT;
          y_d        = '0;
          z_d        = angle_clamped;
          idx_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ROTATE: begin
        x_d   = x_rot;
        y_d   = y_rot;
        z_d   = z_rot;
        idx_d = idx_q + 4'd1;
        if (idx_q == LAST_IDX) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // x/y only change in ROTATE, so they are stable while out_valid is high.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.cos_out   = x_q;
`ifdef CORDIC_SIN_OUT_EN
  assign bus.sin_out   = y_q;
`endif

endmodule

// File: tb/tb_cordic_iter_engine.sv
// ---------------------------------------------------------------------------
// tb_cordic_iter_engine
//
// Directed bench for cordic_iter_engine. Stimulus pushes the hand-computed
// expected result into a queue when an angle is accepted; an independent
// monitor pops and compares whenever a result handshake takes place.
// Inputs change 1 time unit after the rising edge, outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_cordic_iter_engine;

  localparam int ITER = 16;
  localparam int TOL  = 16;

  logic clk = 1'b0;
  logic reset;

  cordic_iter_engine_if bus();

  cordic_iter_engine #(.ITERATIONS(ITER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int angle;
    int exp_cos;
    int exp_sin;
    int accept_cycle;
  } exp_t;

  exp_t exp_q[$];

  int checks        = 0;
  int errors        = 0;
  int cycle_cnt     = 0;
  int rise_cycle    = 0;
  int last_hs_cycle = -1;
  bit prev_valid    = 1'b0;

  // Free-running edge counter used for latency and spacing measurements.
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Compare with a tolerance; every call is one counted comparison.
  task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
    int diff;
    checks++;
    diff = actual - expected;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", name, actual, expected, tol);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an angle and hold it until the engine takes it; the expected
  // result is queued for the monitor at the moment of acceptance.
  task automatic applyStimulus(input int angle, input int exp_cos, input int exp_sin, output int acc_cycle);
    exp_t e;
    bit   done;
    done         = 1'b0;
    acc_cycle    = -1;
    bus.in_valid = 1'b1;
    bus.angle_in = 21'(angle);
    for (int n = 0; n < 200 && !done; n++) begin
      if (bus.in_ready) begin
        e.angle        = angle;
        e.exp_cos      = exp_cos;
        e.exp_sin      = exp_sin;
        e.accept_cycle = cycle_cnt + 1;
        acc_cycle      = e.accept_cycle;
        exp_q.push_back(e);
        done = 1'b1;
      end
      step();
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: angle %0d never accepted, got in_ready %0b, expected 1", angle, bus.in_ready);
    end
  endtask

  // Wait until every queued result has been observed by the monitor.
  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) step();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: records when out_valid rises and scores every result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) rise_cycle = cycle_cnt;
      if (bus.out_valid && bus.out_ready) begin
        last_hs_cycle = cycle_cnt + 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got cos %0d with no pending angle, expected no out_valid", bus.cos_out);
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("cos(%0d)", e.angle), int'(bus.cos_out), e.exp_cos, TOL);
`ifdef CORDIC_SIN_OUT_EN
          checkOutput($sformatf("sin(%0d)", e.angle), int'(bus.sin_out), e.exp_sin, TOL);
`endif
          checkOutput($sformatf("latency(%0d)", e.angle), rise_cycle - e.accept_cycle, ITER, 0);
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  // Hard stop in case something blocks outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int seen;
    int bb_acc   [4];
    int bb_angle [4] = '{0, 274517, -274517, 823550};
    int bb_cos   [4] = '{524288, 454047, 454047, 0};
    int bb_sin   [4] = '{0, 262144, -262144, 524288};

    bus.in_valid  = 1'b0;
    bus.angle_in  = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    $display("[TB] checking reset state");
    checkOutput("reset_in_ready", int'(bus.in_ready), 1, 0);
    checkOutput("reset_out_valid", int'(bus.out_valid), 0, 0);
    checkOutput("reset_busy", int'(bus.busy), 0, 0);
    checkOutput("reset_cos_out", int'(bus.cos_out), 0, 0);
`ifdef CORDIC_SIN_OUT_EN
    checkOutput("reset_sin_out", int'(bus.sin_out), 0, 0);
`endif
    step();

    // Single angles including both clamp directions
    $display("[TB] single angles");
    bus.out_ready = 1'b1;
    applyStimulus(0, 524288, 0, acc);            drain();
    applyStimulus(549033, 262144, 454047, acc);  drain();
    applyStimulus(-549033, 262144, -454047, acc); drain();
    applyStimulus(1000000, 0, 524288, acc);      drain();
    applyStimulus(-1000000, 0, -524288, acc);    drain();

    // Backpressure: hold the result while a new angle waits upstream
    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(549033, 262144, 454047, acc);
    for (int n = 0; n < 100 && !bus.out_valid; n++) step();
    checkOutput("bp_result_arrived", int'(bus.out_valid), 1, 0);
    bus.in_valid = 1'b1;
    bus.angle_in = -21'sd274517;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_out_valid_held", int'(bus.out_valid), 1, 0);
      checkOutput("bp_in_ready_low", int'(bus.in_ready), 0, 0);
      checkOutput("bp_cos_held", int'(bus.cos_out), 262144, TOL);
`ifdef CORDIC_SIN_OUT_EN
      checkOutput("bp_sin_held", int'(bus.sin_out), 454047, TOL);
`endif
      step();
    end
    bus.out_ready = 1'b1;
    applyStimulus(-274517, 454047, -262144, acc);
    checkOutput("bp_turnaround", acc - last_hs_cycle, 1, 0);
    drain();

    // Reset in the middle of a rotation
    $display("[TB] reset mid-rotation");
    applyStimulus(274517, 454047, 262144, acc);
    repeat (7) step();
    checkOutput("busy_mid_rotation", int'(bus.busy), 1, 0);
    exp_q.delete();
    reset = 1'b1;
    #1;
    checkOutput("async_reset_out_valid", int'(bus.out_valid), 0, 0);
    checkOutput("async_reset_busy", int'(bus.busy), 0, 0);
    step();
    step();
    reset = 1'b0;
    checkOutput("post_reset_in_ready", int'(bus.in_ready), 1, 0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    checkOutput("no_stale_result", seen, 0, 0);

    // Back-to-back angles with out_ready tied high
    $display("[TB] back-to-back");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(bb_angle[i], bb_cos[i], bb_sin[i], bb_acc[i]);
    end
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("bb_spacing_%0d", i), bb_acc[i] - bb_acc[i-1], ITER + 2, 0);
    end
    drain();

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
